flush_seq_ctrl: RTL and testbench

Parametrised pipeline flush sequencer, successor to the single-bit delayed flush stage. It accepts a flush request tagged with the originating pipeline stage and drives a per-stage flush vector as a wave: the source stage first, then each younger stage every `DELAY` cycles. It holds the vector for a minimum width and signals completion. It sits between the hazard/exception unit and the per-stage valid registers, and optionally forces a full-pipeline flush out of reset.

---
 rtl/flush_pkg.sv | 21 ++
 rtl/flush_seq_ctrl_tick_ctr.sv | 44 ++++
 rtl/flush_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_flush_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flush_pkg.sv
// Shared types and width helpers for the pipeline flush sequencer.
package flush_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } flush_state_e;

  // Width of the stage-index field: at least one bit even for tiny pipelines.
  function automatic int src_width(input int num_stages);
    return (num_stages <= 2) ? 1 : $clog2(num_stages);
  endfunction

  // Width of a down-counter that must hold values 0..max_val.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flush_seq_ctrl_tick_ctr.sv
// Reloadable saturating down-counter with a terminal-count flag.
// Used both for the wave step delay and for the hold-width count.
module flush_tick_ctr
  import flush_pkg::*;
#(
  parameter int MAX_VAL   = 1,
  parameter int RESET_VAL = 0,
  localparam int W        = ctr_width(MAX_VAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a reload wins over counting; counting stops at zero.
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= W'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/flush_seq_ctrl.sv
// Pipeline flush sequencer: asserts a per-stage flush vector as a wave from
// the requesting stage down to fetch, holds it, then pulses completion.
module flush_seq_ctrl
  import flush_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int DELAY       = 1,
  parameter int HOLD_CYCLES = 2,
  parameter bit RESET_FLUSH = 1'b1,
  localparam int SRC_W      = src_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_req,
  input  logic [SRC_W-1:0]      flush_src,
  output logic [NUM_STAGES-1:0] flush_vec,
  output logic                  flush_busy,
  output logic                  flush_done
);

  localparam int DLY_W = ctr_width(DELAY);
  localparam int HLD_W = ctr_width(HOLD_CYCLES);

  localparam logic [SRC_W-1:0]      MAX_SRC    = SRC_W'(NUM_STAGES - 1);
  localparam logic [DLY_W-1:0]      DLY_RELOAD = DLY_W'(DELAY - 1);
  localparam logic [HLD_W-1:0]      HLD_RELOAD = HLD_W'(HOLD_CYCLES - 1);
  localparam flush_state_e          RST_STATE  = RESET_FLUSH ? HOLD : IDLE;
  localparam logic [NUM_STAGES-1:0] RST_VEC    = RESET_FLUSH ? '1 : '0;
  localparam logic [SRC_W-1:0]      RST_CUR    = RESET_FLUSH ? MAX_SRC : '0;

  flush_state_e          state_q, state_d;
  logic [NUM_STAGES-1:0] vec_q, vec_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SRC_W-1:0]      cur_q, cur_d;   // oldest stage being flushed
  logic [SRC_W-1:0]      wave_q, wave_d; // youngest stage reached by the wave

  logic [SRC_W-1:0] src_c;
  logic [SRC_W-1:0] wave_dec;
  logic             dly_load, dly_en, dly_tc;
  logic             hld_load, hld_en, hld_tc;

  // Contiguous mask with bits lo..hi set (empty when lo > hi).
  function automatic logic [NUM_STAGES-1:0] span(input int lo, input int hi);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

  // Out-of-range sources flush the whole pipeline.
  assign src_c    = (flush_src > MAX_SRC) ? MAX_SRC : flush_src;
  assign wave_dec = wave_q - SRC_W'(1);

  flush_tick_ctr #(
    .MAX_VAL   (DELAY),
    .RESET_VAL (DELAY - 1)
  ) u_dly_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dly_load),
    .load_val_i (DLY_RELOAD),
    .en_i       (dly_en),
    .tc_o       (dly_tc)
  );

  flush_tick_ctr #(
    .MAX_VAL   (HOLD_CYCLES),
    .RESET_VAL (HOLD_CYCLES - 1)
  ) u_hld_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hld_load),
    .load_val_i (HLD_RELOAD),
    .en_i       (hld_en),
    .tc_o       (hld_tc)
  );

  // Next-state and next-output decode for the flush sequence.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cur_d    = cur_q;
    wave_d   = wave_q;
    dly_load = 1'b0;
    dly_en   = 1'b0;
    hld_load = 1'b0;
    hld_en   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
        if (flush_req) begin
          cur_d    = src_c;
          wave_d   = src_c;
          vec_d    = span(int'(src_c), int'(src_c));
          busy_d   = 1'b1;
          dly_load = 1'b1;
          // A fetch-stage source is already complete: the first cycle is hold cycle 1.
          if (src_c == '0) begin
            state_d  = HOLD;
            hld_load = 1'b1;
          end else begin
            state_d  = SWEEP;
          end
        end
      end

      SWEEP: begin
        dly_en = 1'b1;
        if (dly_tc) begin
          dly_load = 1'b1;
          wave_d   = wave_dec;
          vec_d    = vec_d | span(int'(wave_dec), int'(wave_dec));
          if (wave_dec == '0) begin
            state_d  = HOLD;
            hld_load = 1'b1;
          end
        end
        // An older source widens the flush upward; the wave keeps its pace.
        if (flush_req && (src_c > cur_q)) begin
          vec_d = vec_d | span(int'(cur_q) + 1, int'(src_c));
          cur_d = src_c;
        end
      end

      HOLD: begin
        hld_en = 1'b1;
        if (flush_req) begin
          // Any request while holding restarts the minimum width.
          hld_load = 1'b1;
          if (src_c > cur_q) begin
            vec_d = vec_d | span(int'(cur_q) + 1, int'(src_c));
            cur_d = src_c;
          end
        end else if (hld_tc) begin
          state_d = DONE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      vec_q   <= RST_VEC;
      busy_q  <= RESET_FLUSH;
      done_q  <= 1'b0;
      cur_q   <= RST_CUR;
      wave_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      wave_q  <= wave_d;
    end
  end

  assign flush_vec  = vec_q;
  assign flush_busy = busy_q;
  assign flush_done = done_q;

endmodule

// File: tb/tb_flush_seq_ctrl.sv
// Randomized and directed bench for flush_seq_ctrl. Two instances run side
// by side: defaults (DELAY=1, RESET_FLUSH=1) and DELAY=2 with RESET_FLUSH=0.
// Expected outputs come from a timing model built on edge arithmetic.
module tb_flush_seq_ctrl;

  localparam int N   = 5;
  localparam int D_A = 1;
  localparam int H_A = 2;
  localparam int D_B = 2;
  localparam int H_B = 2;

  logic         clk = 1'b0;
  logic         rst_a, rst_b, req;
  logic [2:0]   src;
  logic [N-1:0] vec_a, vec_b;
  logic         busy_a, done_a, busy_b, done_b;

  int n_checks = 0;
  int n_pass   = 0;
  int e        = 0;  // number of rising edges seen; period p(e) follows edge e

  // One flush in flight: accepted at edge k with source s0, oldest stage cur,
  // hold restarted so that period 'restart' is hold cycle 1 (-1 if never).
  typedef struct {
    bit in_rst;
    bit active;
    int k;
    int s0;
    int cur;
    int restart;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  flush_seq_ctrl #(
    .NUM_STAGES (N), .DELAY (D_A), .HOLD_CYCLES (H_A), .RESET_FLUSH (1'b1)
  ) u_dut_a (
    .clk (clk), .reset (rst_a), .flush_req (req), .flush_src (src),
    .flush_vec (vec_a), .flush_busy (busy_a), .flush_done (done_a)
  );

  flush_seq_ctrl #(
    .NUM_STAGES (N), .DELAY (D_B), .HOLD_CYCLES (H_B), .RESET_FLUSH (1'b0)
  ) u_dut_b (
    .clk (clk), .reset (rst_b), .flush_req (req), .flush_src (src),
    .flush_vec (vec_b), .flush_busy (busy_b), .flush_done (done_b)
  );

  function automatic int first_hold(input mdl_t m, input int d);
    return m.k + m.s0 * d;
  endfunction

  function automatic int done_period(input mdl_t m, input int d, input int h);
    int fh;
    fh = first_hold(m, d);
    return ((m.restart > fh) ? m.restart : fh) + h;
  endfunction

  // Expected outputs during period p.
  function automatic void expect_out(input mdl_t m, input int d, input int h, input bit rf,
                                     input int p, output logic [N-1:0] vec,
                                     output logic busy, output logic done);
    int dp, wave;
    vec = '0; busy = 1'b0; done = 1'b0;
    if (m.in_rst) begin
      if (rf) begin
        vec  = '1;
        busy = 1'b1;
      end
      return;
    end
    if (!m.active) return;
    dp = done_period(m, d, h);
    if (p == dp) begin
      done = 1'b1;
    end else if (p < dp) begin
      wave = m.s0 - (p - m.k) / d;
      if (wave < 0) wave = 0;
      for (int j = 0; j < N; j++) vec[j] = (j >= wave) && (j <= m.cur);
      busy = 1'b1;
    end
  endfunction

  // Apply a request sampled at edge ed.
  function automatic mdl_t step(input mdl_t m, input int d, input int h, input int ed,
                                input logic r, input int s_raw);
    int s;
    if (m.in_rst || !r) return m;
    s = (s_raw > N - 1) ? N - 1 : s_raw;
    if (!m.active || (ed - 1 >= done_period(m, d, h))) begin
      m.active  = 1'b1;
      m.k       = ed;
      m.s0      = s;
      m.cur     = s;
      m.restart = -1;
    end else begin
      if (ed - 1 >= first_hold(m, d)) m.restart = ed;
      if (s > m.cur) m.cur = s;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, e, got, exp);
  endtask

  task automatic compare_dut(input string name, input mdl_t m, input int d, input int h,
                             input bit rf, input logic [N-1:0] vec, input logic busy,
                             input logic done);
    logic [N-1:0] ev;
    logic         eb, ed;
    expect_out(m, d, h, rf, e, ev, eb, ed);
    check({name, "_vec"},  32'(vec),  32'(ev));
    check({name, "_busy"}, 32'(busy), 32'(eb));
    check({name, "_done"}, 32'(done), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    ma = step(ma, D_A, H_A, e, req, int'(src));
    mb = step(mb, D_B, H_B, e, req, int'(src));
    #1;
    compare_dut("a", ma, D_A, H_A, 1'b1, vec_a, busy_a, done_a);
    compare_dut("b", mb, D_B, H_B, 1'b0, vec_b, busy_b, done_b);
  endtask

  // Mid-cycle asynchronous reset; outputs must change without a clock edge.
  task automatic assert_rst(input bit is_a);
    #2;
    if (is_a) begin
      rst_a = 1'b1; ma.in_rst = 1'b1; ma.active = 1'b0;
    end else begin
      rst_b = 1'b1; mb.in_rst = 1'b1; mb.active = 1'b0;
    end
    #1;
    if (is_a) compare_dut("a_arst", ma, D_A, H_A, 1'b1, vec_a, busy_a, done_a);
    else      compare_dut("b_arst", mb, D_B, H_B, 1'b0, vec_b, busy_b, done_b);
  endtask

  // Release in the current period; for A that period is hold cycle 1.
  task automatic release_rst(input bit is_a);
    if (is_a) begin
      rst_a = 1'b0;
      ma    = '{1'b0, 1'b1, e, 0, N - 1, -1};
    end else begin
      rst_b = 1'b0;
      mb    = '{1'b0, 1'b0, 0, 0, 0, -1};
    end
  endtask

  logic [N-1:0] src3_tbl [6];
  int           rst_left_a, rst_left_b;

  initial begin
    src3_tbl = '{5'b01000, 5'b01100, 5'b01110, 5'b01111, 5'b01111, 5'b00000};
    rst_a = 1'b1; rst_b = 1'b1; req = 1'b0; src = '0;
    ma = '{1'b1, 1'b0, 0, 0, 0, -1};
    mb = '{1'b1, 1'b0, 0, 0, 0, -1};

    // Reset: A shows the full flush, B is quiet.
    repeat (3) tick();
    check("rst_a_vec", 32'(vec_a), 32'h1f);
    check("rst_b_vec", 32'(vec_b), 32'h0);
    release_rst(1'b1);
    release_rst(1'b0);
    tick();
    check("rstflush_hold2", 32'(vec_a), 32'h1f);
    tick();
    check("rstflush_done", 32'(done_a), 32'h1);
    check("rstflush_vec0", 32'(vec_a), 32'h0);
    repeat (4) tick();
    check("rf0_quiet", 32'({vec_b, busy_b, done_b}), 32'h0);

    // src=3 wave on A.
    req = 1'b1; src = 3'd3;
    tick();
    req = 1'b0;
    check("src3_c0", 32'(vec_a), 32'(src3_tbl[0]));
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("src3_c%0d", i), 32'(vec_a), 32'(src3_tbl[i]));
    end
    check("src3_done", 32'(done_a), 32'h1);

    // Request in the DONE cycle, source 7 clamps to stage 4.
    req = 1'b1; src = 3'd7;
    tick();
    req = 1'b0;
    check("done_accept_busy", 32'(busy_a), 32'h1);
    check("clamp_vec", 32'(vec_a), 32'h10);
    repeat (12) tick();

    // Merge during sweep: src=2 then src=4.
    req = 1'b1; src = 3'd2;
    tick();
    src = 3'd4;
    tick();
    req = 1'b0;
    check("merge_vec", 32'(vec_a), 32'h1e);
    repeat (2) tick();
    tick();
    check("merge_done", 32'(done_a), 32'h1);
    repeat (12) tick();

    // Hold restart: src=1, then a request in hold cycle 1.
    req = 1'b1; src = 3'd1;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; src = 3'd0;
    tick();
    req = 1'b0;
    tick();
    check("hold_ext_busy", 32'(busy_a), 32'h1);
    check("hold_ext_nodone", 32'(done_a), 32'h0);
    tick();
    check("hold_ext_done", 32'(done_a), 32'h1);
    repeat (12) tick();

    // src=0 goes straight to hold.
    req = 1'b1; src = 3'd0;
    tick();
    req = 1'b0;
    check("src0_c0", 32'(vec_a), 32'h01);
    tick();
    check("src0_c1", 32'(vec_a), 32'h01);
    tick();
    check("src0_done", 32'(done_a), 32'h1);
    repeat (12) tick();

    // DELAY=2 full flush of src=2: done six periods after acceptance.
    req = 1'b1; src = 3'd2;
    tick();
    req = 1'b0;
    repeat (6) tick();
    check("d2_done", 32'(done_b), 32'h1);
    repeat (14) tick();

    // DELAY=2 flush aborted by reset: no done pulse afterwards.
    req = 1'b1; src = 3'd2;
    tick();
    req = 1'b0;
    check("d2_bit2", 32'(vec_b), 32'h04);
    repeat (2) tick();
    check("d2_bit1", 32'(vec_b), 32'h06);
    assert_rst(1'b0);
    check("d2_abort_vec", 32'(vec_b), 32'h0);
    repeat (6) tick();
    release_rst(1'b0);
    repeat (4) tick();

    // Random requests, sources and occasional asynchronous resets.
    rst_left_a = 0;
    rst_left_b = 0;
    for (int it = 0; it < 1500; it++) begin
      req = ($urandom_range(0, 9) < 3);
      src = 3'($urandom_range(0, 7));
      tick();
      if (rst_left_a > 0) begin
        rst_left_a--;
        if (rst_left_a == 0) release_rst(1'b1);
      end else if ($urandom_range(0, 299) == 0) begin
        assert_rst(1'b1);
        rst_left_a = $urandom_range(1, 3);
      end
      if (rst_left_b > 0) begin
        rst_left_b--;
        if (rst_left_b == 0) release_rst(1'b0);
      end else if ($urandom_range(0, 299) == 0) begin
        assert_rst(1'b0);
        rst_left_b = $urandom_range(1, 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
